// File: rtl/data_memory_stall.sv
// data_memory_stall: MEM-stage data memory with byte/halfword/word accesses.
// Each access takes a fixed WAIT_STATES+2 cycles. mem_stall holds the pipeline
// while the access is in flight. The access commits on the edge that enters DONE,
// which is the cycle where mem_done pulses. Misaligned and out-of-range accesses
// take the same number of cycles. They never write the array and they return zero.
module data_memory_stall #(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        ctrl_mem_read,
    input  logic        ctrl_mem_write,
    input  logic [1:0]  ctrl_mem_size,
    input  logic        ctrl_mem_signed,
    output logic [31:0] read_data,
    output logic        mem_stall,
    output logic        mem_done,
    output logic        misaligned,
    output logic        out_of_range
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [CW-1:0]       cnt_r;
    logic [31:0]         read_data_r;
    logic                misaligned_r;
    logic                out_of_range_r;
    logic [31:0]         mem_r [DEPTH];

    logic                request_s;
    logic                commit_s;
    logic                mem_we_s;
    logic                is_byte_s;
    logic                is_half_s;
    logic                misaligned_s;
    logic                oor_s;
    logic                error_s;
    logic [DEPTH_LOG2-1:0] word_idx_s;
    logic [31:0]         cur_word_s;
    logic [31:0]         load_s;
    logic [3:0]          wmask_s;
    logic [31:0]         wdata_rep_s;
    logic [31:0]         new_word_s;

    // Selects the byte or halfword addressed by off and extends it to 32 bits.
    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'd0, b};
            2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Returns the byte-lane write mask for a store of the given size and offset.
    function automatic logic [3:0] lane_mask(
        input logic [1:0] off,
        input logic [1:0] size
    );
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    assign request_s    = ctrl_mem_read | ctrl_mem_write;
    assign is_byte_s    = (ctrl_mem_size == 2'b00);
    assign is_half_s    = (ctrl_mem_size == 2'b01);
    assign misaligned_s = (is_half_s & address[0]) |
                          (~is_byte_s & ~is_half_s & (address[1:0] != 2'b00));
    assign oor_s        = (address >> (DEPTH_LOG2 + 2)) != 32'd0;
    assign error_s      = misaligned_s | oor_s;
    assign word_idx_s   = address[DEPTH_LOG2+1:2];
    assign cur_word_s   = mem_r[word_idx_s];
    assign load_s       = extract_load(cur_word_s, address[1:0], ctrl_mem_size, ctrl_mem_signed);
    assign wmask_s      = lane_mask(address[1:0], ctrl_mem_size);

    // The next clock edge enters DONE. This is when the access commits.
    assign commit_s = ((state_r == S_IDLE) && request_s && (WAIT_STATES == 0)) ||
                      ((state_r == S_WAIT) && (cnt_r == '0));

    // The array write is blocked while reset is held so that an aborted access cannot land.
    assign mem_we_s = reset & commit_s & ctrl_mem_write & ~error_s;

    // Replicates the right-aligned store data across every lane it can occupy.
    always_comb begin
        wdata_rep_s = write_data;
        case (ctrl_mem_size)
            2'b00:   wdata_rep_s = {4{write_data[7:0]}};
            2'b01:   wdata_rep_s = {2{write_data[15:0]}};
            default: wdata_rep_s = write_data;
        endcase
    end

    // Merges the store lanes into the current word. Unselected lanes keep their old bytes.
    always_comb begin
        new_word_s = cur_word_s;
        for (int i = 0; i < 4; i++) begin
            new_word_s[8*i +: 8] = wmask_s[i] ? wdata_rep_s[8*i +: 8] : cur_word_s[8*i +: 8];
        end
    end

    // Storage array. It is not reset and is written only on the commit edge.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[word_idx_s] <= new_word_s;
        end
    end

    // Access sequencer. It registers the load result and error flags at commit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= S_IDLE;
            cnt_r          <= '0;
            read_data_r    <= 32'd0;
            misaligned_r   <= 1'b0;
            out_of_range_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (request_s) begin
                        if (WAIT_STATES == 0) begin
                            state_r <= S_DONE;
                        end else begin
                            cnt_r   <= CW'(WAIT_STATES - 1);
                            state_r <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_r == '0) begin
                        state_r <= S_DONE;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
            if (commit_s) begin
                misaligned_r   <= misaligned_s;
                out_of_range_r <= oor_s;
                if (error_s) begin
                    read_data_r <= 32'd0;
                end else if (!ctrl_mem_write) begin
                    read_data_r <= load_s;
                end
            end
        end
    end

    assign read_data    = read_data_r;
    assign misaligned   = misaligned_r;
    assign out_of_range = out_of_range_r;
    assign mem_done     = (state_r == S_DONE);
    assign mem_stall    = reset & (((state_r == S_IDLE) & request_s) | (state_r == S_WAIT));

endmodule

// File: tb/tb_data_memory_stall.sv
// Bench for data_memory_stall. One instance uses two wait states and one uses none.
// The stimulus queues the expected response of each access. The monitors pop it
// and compare when mem_done pulses.
module tb_data_memory_stall;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic        oor;
        string       name;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [1:0]  size;
    logic        sgn;
    logic        rd2, wr2, rd0, wr0;
    logic [31:0] read_data2, read_data0;
    logic        stall2, stall0, done2, done0;
    logic        mis2, mis0, oor2, oor0;

    exp_t q2[$];
    exp_t q0[$];
    int   passed;
    int   total;

    data_memory_stall #(.DEPTH_LOG2(6), .WAIT_STATES(2)) dut2 (
        .clock(clock), .reset(reset), .address(address), .write_data(write_data),
        .ctrl_mem_read(rd2), .ctrl_mem_write(wr2), .ctrl_mem_size(size),
        .ctrl_mem_signed(sgn), .read_data(read_data2), .mem_stall(stall2),
        .mem_done(done2), .misaligned(mis2), .out_of_range(oor2)
    );

    data_memory_stall #(.DEPTH_LOG2(6), .WAIT_STATES(0)) dut0 (
        .clock(clock), .reset(reset), .address(address), .write_data(write_data),
        .ctrl_mem_read(rd0), .ctrl_mem_write(wr0), .ctrl_mem_size(size),
        .ctrl_mem_signed(sgn), .read_data(read_data0), .mem_stall(stall0),
        .mem_done(done0), .misaligned(mis0), .out_of_range(oor0)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation for each mem_done pulse.
    always @(negedge clock) begin
        exp_t e;
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("unexpected_done_w2", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                chk({e.name, "_data"}, read_data2, e.data);
                chk({e.name, "_mis"}, {31'd0, mis2}, {31'd0, e.mis});
                chk({e.name, "_oor"}, {31'd0, oor2}, {31'd0, e.oor});
            end
        end
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("unexpected_done_w0", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk({e.name, "_data"}, read_data0, e.data);
                chk({e.name, "_mis"}, {31'd0, mis0}, {31'd0, e.mis});
                chk({e.name, "_oor"}, {31'd0, oor0}, {31'd0, e.oor});
            end
        end
    end

    // The task is entered just after a rising edge. It holds the request through DONE,
    // checks stall/done each cycle and returns just after the edge that ends DONE.
    task automatic access(input bit use_w0, input bit is_wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz, input logic s,
                          input logic [31:0] exp_d, input logic exp_mis,
                          input logic exp_oor, input string name);
        exp_t e;
        int   w;
        w          = use_w0 ? 0 : 2;
        address    = a;
        write_data = d;
        size       = sz;
        sgn        = s;
        e.data = exp_d; e.mis = exp_mis; e.oor = exp_oor; e.name = name;
        if (use_w0) begin
            wr0 = is_wr; rd0 = ~is_wr; q0.push_back(e);
        end else begin
            wr2 = is_wr; rd2 = ~is_wr; q2.push_back(e);
        end
        for (int c = 0; c <= w + 1; c++) begin
            @(negedge clock);
            chk({name, "_stall"}, {31'd0, use_w0 ? stall0 : stall2}, {31'd0, (c <= w)});
            chk({name, "_done"}, {31'd0, use_w0 ? done0 : done2}, {31'd0, (c == w + 1)});
            @(posedge clock);
            #1;
        end
        rd2 = 1'b0; wr2 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk({name, "_stall"}, {30'd0, stall2, stall0}, 32'd0);
            chk({name, "_done"}, {30'd0, done2, done0}, 32'd0);
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            address    = $urandom();
            write_data = $urandom();
            size       = 2'($urandom_range(3, 0));
            sgn        = 1'($urandom_range(1, 0));
            rd2 = 1'($urandom_range(1, 0)); wr2 = 1'b1;
            rd0 = 1'b1; wr0 = 1'($urandom_range(1, 0));
            #7;
            chk("rst_read_data", read_data2 | read_data0, 32'd0);
            chk("rst_flags", {28'd0, mis2, mis0, oor2, oor0}, 32'd0);
            chk("rst_done", {30'd0, done2, done0}, 32'd0);
            chk("rst_stall", {30'd0, stall2, stall0}, 32'd0);
        end
        rd2 = 1'b0; wr2 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
        address = 32'd0; write_data = 32'd0; size = 2'b10; sgn = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        idle_cycles(3, "idle_after_reset");

        // Word, byte and halfword accesses with two wait states.
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0, "sw_10");
        access(1'b0, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, "lw_10");
        access(1'b0, 1'b1, 32'h13, 32'h80,       2'b00, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, "sb_13");
        access(1'b0, 1'b0, 32'h13, 32'h0,        2'b00, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0, "lb_13");
        access(1'b0, 1'b0, 32'h13, 32'h0,        2'b00, 1'b0, 32'h00000080, 1'b0, 1'b0, "lbu_13");
        access(1'b0, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h80ADBEEF, 1'b0, 1'b0, "lw_10b");
        access(1'b0, 1'b1, 32'h12, 32'h8001,     2'b01, 1'b0, 32'h80ADBEEF, 1'b0, 1'b0, "sh_12");
        access(1'b0, 1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 32'hFFFF8001, 1'b0, 1'b0, "lh_12");
        access(1'b0, 1'b0, 32'h12, 32'h0,        2'b01, 1'b0, 32'h00008001, 1'b0, 1'b0, "lhu_12");
        access(1'b0, 1'b0, 32'h11, 32'h0,        2'b00, 1'b0, 32'h000000BE, 1'b0, 1'b0, "lbu_11");
        // Error accesses.
        access(1'b0, 1'b0, 32'h12, 32'h0,        2'b10, 1'b0, 32'h0,        1'b1, 1'b0, "lw_12_mis");
        access(1'b0, 1'b1, 32'h11, 32'h5555,     2'b01, 1'b0, 32'h0,        1'b1, 1'b0, "sh_11_mis");
        access(1'b0, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h8001BEEF, 1'b0, 1'b0, "lw_10_unch");
        access(1'b0, 1'b0, 32'h100, 32'h0,       2'b10, 1'b0, 32'h0,        1'b0, 1'b1, "lw_100_oor");
        access(1'b0, 1'b0, 32'h102, 32'h0,       2'b10, 1'b0, 32'h0,        1'b1, 1'b1, "lw_102_both");
        access(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0, "sw_20");

        // Reset during the second WAIT cycle aborts the store.
        wr2 = 1'b1; address = 32'h20; write_data = 32'h12345678; size = 2'b10;
        @(negedge clock);
        chk("abort_c0_stall", {31'd0, stall2}, 32'd1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("abort_c1_stall", {31'd0, stall2}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("abort_rst_stall", {31'd0, stall2}, 32'd0);
        chk("abort_rst_done", {31'd0, done2}, 32'd0);
        wr2 = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        idle_cycles(2, "idle_after_abort");
        access(1'b0, 1'b0, 32'h20, 32'h0,        2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, "lw_20_prior");

        // No wait states: expect stall 1,0,0,1,0 and one access per request.
        access(1'b1, 1'b1, 32'h30, 32'h11112222, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0, "w0_sw_30");
        idle_cycles(1, "w0_gap");
        access(1'b1, 1'b1, 32'h34, 32'h33334444, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0, "w0_sw_34");
        access(1'b1, 1'b0, 32'h30, 32'h0,        2'b10, 1'b0, 32'h11112222, 1'b0, 1'b0, "w0_lw_30");
        access(1'b1, 1'b0, 32'h34, 32'h0,        2'b10, 1'b0, 32'h33334444, 1'b0, 1'b0, "w0_lw_34");
        idle_cycles(2, "final_idle");

        chk("q2_drained", q2.size(), 32'd0);
        chk("q0_drained", q0.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
